// File: rtl/soc_conf_pkg.sv
// Shared SoC config-window constants and a byte-lane merge helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package soc_conf_pkg;

  localparam logic [15:0] CONF_HI     = 16'hbfaf;
  localparam logic [15:0] CONF_LED    = 16'h0000;
  localparam logic [15:0] CONF_NUM    = 16'h0004;
  localparam logic [15:0] CONF_SWITCH = 16'h0008;
  localparam logic [15:0] CONF_TIMER  = 16'he000;
  localparam int          DEF_ADDR_W  = 14;

  // Replace each byte of cur whose enable bit is set with the matching byte of wd.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_if.sv
// CPU data SRAM request/response bundle.
// Latency: rdata valid one cycle after an enabled request.
// Backpressure: none; a request is accepted every cycle.
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/sram_bytewr_ram.sv
// Single-port word RAM with per-byte write enables, read-before-write output.
// Latency: 1 cycle; output register holds when en=0.
// Backpressure: none; writes are suppressed while resetn is low.
module sram_bytewr_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes; contents survive reset, only the write is blocked.
  always_ff @(posedge clk) begin
    if (resetn && en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Output register captures the pre-write word on every enabled access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: block RAM plus LED/NUM/SWITCH/TIMER config window.
// Latency: 1 cycle read; config reads return pre-edge register values.
// Backpressure: none; every cycle accepts a request, rdata holds when idle.
module data_sram_resp #(
  parameter int          ADDR_W  = soc_conf_pkg::DEF_ADDR_W,
  parameter logic [15:0] CONF_HI = soc_conf_pkg::CONF_HI
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_if.slave        data_sram,
  output logic [15:0]       led,
  output logic [31:0]       num,
  input  logic [15:0]       switch
);
  import soc_conf_pkg::*;

  logic        req_conf;
  logic [15:0] conf_off;
  logic        conf_wr;
  logic [31:0] conf_rd_val;
  logic [31:0] led_wr;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] timer;
  logic [31:0] conf_rdata;
  logic        sel_conf;
  logic [31:0] ram_rdata;
  logic        unused_bits;

  assign req_conf    = (data_sram.addr[31:16] == CONF_HI);
  assign conf_off    = data_sram.addr[15:0];
  assign conf_wr     = data_sram.en && req_conf && (data_sram.wen != 4'b0);
  assign led_wr      = byte_merge({16'h0000, led}, data_sram.wdata, data_sram.wen);
  assign unused_bits = ^{data_sram.addr[1:0], led_wr[31:16]};

  sram_bytewr_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en     (data_sram.en && !req_conf),
    .wen    (data_sram.wen),
    .addr   (data_sram.addr[ADDR_W+1:2]),
    .wdata  (data_sram.wdata),
    .rdata  (ram_rdata)
  );

  // Config read value as seen before this edge's writes and timer increment.
  always_comb begin
    conf_rd_val = 32'h0;
    case (conf_off)
      CONF_LED:    conf_rd_val = {16'h0000, led};
      CONF_NUM:    conf_rd_val = num;
      CONF_SWITCH: conf_rd_val = {16'h0000, sw_sync};
      CONF_TIMER:  conf_rd_val = timer;
      default:     conf_rd_val = 32'h0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // LED and NUM registers, byte-enable writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led <= '0;
      num <= '0;
    end else if (conf_wr) begin
      if (conf_off == CONF_LED) led <= led_wr[15:0];
      if (conf_off == CONF_NUM) num <= byte_merge(num, data_sram.wdata, data_sram.wen);
    end
  end

  // Free-running timer; a write freezes unwritten bytes for that one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer <= '0;
    else if (conf_wr && conf_off == CONF_TIMER)
      timer <= byte_merge(timer, data_sram.wdata, data_sram.wen);
    else
      timer <= timer + 32'd1;
  end

  // Registered config read data and region select for the output mux.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conf_rdata <= '0;
      sel_conf   <= 1'b0;
    end else if (data_sram.en) begin
      sel_conf <= req_conf;
      if (req_conf) conf_rdata <= conf_rd_val;
    end
  end

  assign data_sram.rdata = sel_conf ? conf_rdata : ram_rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench with an abstract memory-map model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] led;
  logic [31:0] num;
  logic [15:0] switch = 16'h0;

  data_sram_if bus ();

  data_sram_resp dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_sram (bus),
    .led       (led),
    .num       (num),
    .switch    (switch)
  );

  always #5 clk = ~clk;

  // Abstract model of what the core should observe.
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata = 0;
  logic [15:0] m_led   = 0;
  logic [31:0] m_num   = 0;
  logic [31:0] m_timer = 0;
  logic [15:0] m_sw1   = 0;
  logic [15:0] m_sw2   = 0;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_rdata = 0; m_led = 0; m_num = 0; m_timer = 0; m_sw1 = 0; m_sw2 = 0;
  endtask

  // What one clock edge does to the memory map, in plain terms.
  task automatic model_edge(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bit conf;
    int off;
    int idx;
    bit timer_written;
    conf = (addr[31:16] == 16'hbfaf);
    off = int'(addr[15:0]);
    idx = int'(addr[15:2]);
    timer_written = 0;
    if (en) begin
      if (conf) begin
        case (off)
          'h0000: m_rdata = {16'h0, m_led};
          'h0004: m_rdata = m_num;
          'h0008: m_rdata = {16'h0, m_sw2};
          'he000: m_rdata = m_timer;
          default: m_rdata = 0;
        endcase
        if (wen != 0) begin
          if (off == 'h0000) begin
            m_led[7:0]  = wen[0] ? wdata[7:0]  : m_led[7:0];
            m_led[15:8] = wen[1] ? wdata[15:8] : m_led[15:8];
          end
          if (off == 'h0004) m_num = merge(m_num, wdata, wen);
          if (off == 'he000) begin
            m_timer = merge(m_timer, wdata, wen);
            timer_written = 1;
          end
        end
      end else begin
        m_rdata = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        m_mem[idx] = merge(m_rdata, wdata, wen);
      end
    end
    if (!timer_written) m_timer = m_timer + 1;
    m_sw2 = m_sw1;
    m_sw1 = switch;
  endtask

  // Drive one request just after a falling edge, step through the rising edge.
  task automatic cyc(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus.en = en; bus.wen = wen; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    if (resetn) model_edge(en, wen, addr, wdata);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Hand-computed literal pins both the DUT and the model.
  task automatic pin(input string name, input logic [31:0] lit);
    chk({name, "_dut"}, bus.rdata, lit);
    chk({name, "_model"}, m_rdata, lit);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("rdata", bus.rdata, m_rdata);
      chk("led", {16'h0, led}, {16'h0, m_led});
      chk("num", num, m_num);
    end
  end

  initial begin
    bus.en = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0;
    model_reset();
    @(negedge clk);
    run = 1'b1;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_num", num, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // RAM word round trip.
    cyc(1, 4'hF, 32'h0000_0100, 32'h12345678);
    cyc(1, 4'h0, 32'h0000_0100, 32'h0);
    pin("ram_rt", 32'h12345678);

    // Byte lanes, idle hold, alias.
    cyc(1, 4'b0101, 32'h0000_0100, 32'hAABBCCDD);
    cyc(1, 4'h0, 32'h0000_0100, 32'h0);
    pin("byte_lanes", 32'h12BB56DD);
    cyc(0, 4'h0, 32'h0000_0200, 32'h0);
    pin("idle_hold", 32'h12BB56DD);
    cyc(1, 4'h0, 32'h0001_0100, 32'h0);
    pin("alias", 32'h12BB56DD);

    // Read-before-write.
    cyc(1, 4'hF, 32'h0000_0200, 32'h11111111);
    cyc(1, 4'hF, 32'h0000_0200, 32'h22222222);
    pin("rbw_old", 32'h11111111);
    cyc(1, 4'h0, 32'h0000_0200, 32'h0);
    pin("rbw_new", 32'h22222222);

    // Timer load and wrap.
    cyc(1, 4'hF, 32'hbfaf_e000, 32'hFFFFFFFE);
    cyc(1, 4'h0, 32'hbfaf_e000, 32'h0);
    pin("timer_ld", 32'hFFFFFFFE);
    cyc(1, 4'h0, 32'hbfaf_e000, 32'h0);
    pin("timer_inc", 32'hFFFFFFFF);
    cyc(1, 4'h0, 32'hbfaf_e000, 32'h0);
    pin("timer_wrap", 32'h00000000);

    // Timer byte write keeps upper bytes un-incremented.
    cyc(1, 4'hF, 32'hbfaf_e000, 32'h12345600);
    cyc(1, 4'b0001, 32'hbfaf_e000, 32'h00000005);
    cyc(1, 4'h0, 32'hbfaf_e000, 32'h0);
    pin("timer_byte", 32'h12345605);

    // LED / NUM.
    cyc(1, 4'hF, 32'hbfaf_0000, 32'h0000A5A5);
    chk("led_wr", {16'h0, led}, 32'h0000A5A5);
    cyc(1, 4'b1010, 32'hbfaf_0004, 32'hCAFEF00D);
    chk("num_wr", num, 32'hCA00F000);
    cyc(1, 4'h0, 32'hbfaf_0004, 32'h0);
    pin("num_rd", 32'hCA00F000);
    cyc(1, 4'h0, 32'hbfaf_0000, 32'h0);
    pin("led_rd", 32'h0000A5A5);

    // Switch through the synchronizer.
    switch = 16'h00F0;
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(1, 4'h0, 32'hbfaf_0008, 32'h0);
    pin("switch", 32'h000000F0);

    // Unmapped offset: write ignored, reads zero.
    cyc(1, 4'hF, 32'hbfaf_0020, 32'h55555555);
    cyc(1, 4'h0, 32'hbfaf_0020, 32'h0);
    pin("unmapped", 32'h0);
    cyc(1, 4'h0, 32'hbfaf_0000, 32'h0);
    pin("led_kept", 32'h0000A5A5);

    // Reset dropped in the middle of a RAM write.
    bus.en = 1; bus.wen = 4'hF; bus.addr = 32'h0000_0100; bus.wdata = 32'hDEADBEEF;
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_num", num, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.en = 0;
    resetn = 1'b1;
    cyc(1, 4'h0, 32'hbfaf_e000, 32'h0);
    pin("rst_timer", 32'h0);
    cyc(1, 4'h0, 32'h0000_0100, 32'h0);
    pin("rst_nowrite", 32'h12BB56DD);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
